// File: rtl/parking_counter.sv
// Parking-lot occupancy counter: saturating binary count with a parallel BCD
// pair, derived free/full/empty status and sticky overflow/underflow flags.
module parking_counter #(
    parameter int CAPACITY = 25,
    parameter int CW       = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          incr,
    input  logic          decr,
    input  logic          clr_err,
    output logic [CW-1:0] count,
    output logic [CW-1:0] free,
    output logic [3:0]    bcd_tens,
    output logic [3:0]    bcd_ones,
    output logic          full,
    output logic          empty,
    output logic          ovf_err,
    output logic          unf_err
);

    localparam logic [CW-1:0] CAP = CW'(CAPACITY);

    typedef enum logic [1:0] {
        MODE_HOLD,
        MODE_INC,
        MODE_DEC
    } mode_e;

    mode_e         mode;

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free_q, free_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          ovfSet, unfSet;

    // Simultaneous incr and decr cancel out and are treated as an idle cycle.
    always_comb begin
        mode = MODE_HOLD;
        if (incr && !decr) begin
            mode = MODE_INC;
        end else if (decr && !incr) begin
            mode = MODE_DEC;
        end
    end

    always_comb begin
        count_d = count_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        ovfSet  = 1'b0;
        unfSet  = 1'b0;
        case (mode)
            MODE_INC: begin
                if (count_q == CAP) begin
                    ovfSet = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
            end
            MODE_DEC: begin
                if (count_q == '0) begin
                    unfSet = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
            default: begin
            end
        endcase

        // Status is derived from the next count so it lands on the same edge.
        free_d  = CAP - count_d;
        full_d  = (count_d == CAP);
        empty_d = (count_d == '0);

        // A freshly raised error wins over a coincident clear.
        ovf_d = ovfSet | (ovf_q & ~clr_err);
        unf_d = unfSet | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            free_q  <= CAP;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            free_q  <= free_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count    = count_q;
    assign free     = free_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign ovf_err  = ovf_q;
    assign unf_err  = unf_q;

endmodule
